// File: rtl/vec_mac_engine.sv
// vec_mac_engine: dot-product engine sitting behind the ICB register/SRAM slave.
// A rising edge on stat_cal[0] (seen while idle) streams len element pairs out
// of SRAM, multiply-accumulates their signed low halves and writes the 32-bit
// sum back to RES_ADDR. Completion is reported through a sticky done bit.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a start edge; done flag holds its last value
// RD_A  | read strobe for A[i] is on the bus
// RD_B  | read strobe for B[i] on the bus; A[i] data arrives and is captured
// MAC   | B[i] data arrives; acc += a*b, advance i
// WRITE | write strobe with the accumulated result
// DONE  | done flag set, busy dropped, return to IDLE
//
// All bus outputs are registered: the strobe/address for a state is loaded on
// the edge that enters that state, so each state's strobe appears in the very
// cycle the FSM occupies it.
module vec_mac_engine #(
    parameter logic [12:0] A_BASE   = 13'd0,
    parameter logic [12:0] B_BASE   = 13'd256,
    parameter logic [12:0] RES_ADDR = 13'd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] stat_cal,
    output logic [15:0] done_reg,
    output logic        mem_rd_en,
    output logic [12:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [12:0] mem_wr_addr,
    output logic [31:0] mem_wr_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        MAC   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state;
    logic        start_prev;
    logic [7:0]  len_r;
    logic [8:0]  idx;
    logic [8:0]  idx_next;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [31:0] a_r;
    logic        done_flag;
    logic        busy;
    logic        trigger;
    logic        last_elem;
    logic signed [31:0] a_ext;
    logic signed [31:0] b_ext;
    logic signed [31:0] prod;

    // Start edge detect, index step and the sign-extended 16x16 product.
    // The low 32 bits of the product of the sign-extended operands equal the
    // exact signed 16x16 product, so no wider multiplier is needed.
    always_comb begin
        trigger   = stat_cal[0] & ~start_prev;
        idx_next  = idx + 9'd1;
        last_elem = (idx_next == {1'b0, len_r});
        a_ext     = {{16{a_r[15]}}, a_r[15:0]};
        b_ext     = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
        prod      = a_ext * b_ext;
        acc_next  = acc + prod;
    end

    assign done_reg = {len_r, 6'b0, busy, done_flag};

    // Sequencer: state, datapath registers and registered bus strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_prev  <= 1'b0;
            len_r       <= 8'd0;
            idx         <= 9'd0;
            acc         <= 32'd0;
            a_r         <= 32'd0;
            done_flag   <= 1'b0;
            busy        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= 13'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 13'd0;
            mem_wr_data <= 32'd0;
        end else begin
            start_prev  <= stat_cal[0];
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= 13'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 13'd0;
            mem_wr_data <= 32'd0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        len_r     <= stat_cal[15:8];
                        acc       <= 32'd0;
                        idx       <= 9'd0;
                        done_flag <= 1'b0;
                        busy      <= 1'b1;
                        if (stat_cal[15:8] == 8'd0) begin
                            state       <= WRITE;
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= RES_ADDR;
                            mem_wr_data <= 32'd0;
                        end else begin
                            state       <= RD_A;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= A_BASE;
                        end
                    end
                end
                RD_A: begin
                    state       <= RD_B;
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= B_BASE + {4'd0, idx};
                end
                RD_B: begin
                    a_r   <= mem_rd_data;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx_next;
                    if (last_elem) begin
                        state       <= WRITE;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= RES_ADDR;
                        mem_wr_data <= acc_next;
                    end else begin
                        state       <= RD_A;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= A_BASE + {4'd0, idx_next};
                    end
                end
                WRITE: begin
                    done_flag <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mac_engine.sv
// Directed bench for vec_mac_engine. Expected SRAM writes and read addresses
// are queued when a run is launched; negedge monitors pop and compare them.
module tb_vec_mac_engine;

    logic        clk;
    logic        rst_n;
    logic [15:0] stat_cal;
    logic [15:0] done_reg;
    logic        mem_rd_en;
    logic [12:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [12:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    logic [15:0] stat_cal2;
    logic [15:0] done_reg2;
    logic        mem_rd_en2;
    logic [12:0] mem_rd_addr2;
    logic [31:0] mem_rd_data2;
    logic        mem_wr_en2;
    logic [12:0] mem_wr_addr2;
    logic [31:0] mem_wr_data2;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    wr_t         wq2[$];
    logic [12:0] raq2[$];

    logic [31:0] mem  [0:8191];
    logic [31:0] mem2 [0:8191];

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;

    vec_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .stat_cal(stat_cal), .done_reg(done_reg),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    vec_mac_engine #(.A_BASE(13'd8190)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stat_cal(stat_cal2), .done_reg(done_reg2),
        .mem_rd_en(mem_rd_en2), .mem_rd_addr(mem_rd_addr2), .mem_rd_data(mem_rd_data2),
        .mem_wr_en(mem_wr_en2), .mem_wr_addr(mem_wr_addr2), .mem_wr_data(mem_wr_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rd_data  <= mem[mem_rd_addr];
        if (mem_rd_en2) mem_rd_data2 <= mem2[mem_rd_addr2];
    end

    // Monitors: compare every presented write / read against the queues.
    always @(negedge clk) begin
        wr_t e;
        logic [12:0] ra;
        if (mem_wr_en) begin
            n_cmp++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%0d data=%h", mem_wr_addr, mem_wr_data);
            end else begin
                e = wq.pop_front();
                if (mem_wr_addr !== e.addr || mem_wr_data !== e.data) begin
                    n_err++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_wr_addr, mem_wr_data, e.addr, e.data);
                end
            end
        end
        if (mem_rd_en) rd_cnt++;
        if (mem_rd_en && mem_wr_en) begin
            n_cmp++;
            n_err++;
            $display("FAIL strobe_overlap rd_en=%b wr_en=%b expected not both", mem_rd_en, mem_wr_en);
        end
        if (mem_wr_en2) begin
            n_cmp++;
            if (wq2.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write2 addr=%0d data=%h", mem_wr_addr2, mem_wr_data2);
            end else begin
                e = wq2.pop_front();
                if (mem_wr_addr2 !== e.addr || mem_wr_data2 !== e.data) begin
                    n_err++;
                    $display("FAIL write2 got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_wr_addr2, mem_wr_data2, e.addr, e.data);
                end
            end
        end
        if (mem_rd_en2) begin
            n_cmp++;
            if (raq2.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read2 addr=%0d", mem_rd_addr2);
            end else begin
                ra = raq2.pop_front();
                if (mem_rd_addr2 !== ra) begin
                    n_err++;
                    $display("FAIL read_addr2 got %0d expected %0d", mem_rd_addr2, ra);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One run on the main instance; start is left high on return.
    task automatic run(input int len, input logic [31:0] exp, input bit toggle);
        int  rd0;
        wr_t e;
        @(negedge clk);
        stat_cal = {len[7:0], 8'h00};
        @(negedge clk);
        e.addr = 13'd512;
        e.data = exp;
        wq.push_back(e);
        rd0 = rd_cnt;
        stat_cal = {len[7:0], 8'h01};
        @(posedge clk);
        for (int k = 1; k <= 3 * len + 2; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_at_t1", {16'd0, done_reg}, {16'd0, len[7:0], 8'h02});
            if (toggle && k == 2) stat_cal[0] = 1'b0;
            if (toggle && k == 3) stat_cal[0] = 1'b1;
            if (k == 3 * len + 1) begin
                chk("wr_en_at_write", {31'd0, mem_wr_en}, 32'd1);
                chk("busy_at_write", {16'd0, done_reg}, {16'd0, len[7:0], 8'h02});
            end
            if (k == 3 * len + 2) chk("done_at_end", {16'd0, done_reg}, {16'd0, len[7:0], 8'h01});
        end
        chk("read_count", rd_cnt - rd0, 2 * len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] exp_ra[8];
        wr_t e;
        for (int a = 0; a < 8192; a++) begin
            mem[a]  = 32'd0;
            mem2[a] = 32'd0;
        end
        rst_n     = 1'b0;
        stat_cal  = 16'h0000;
        stat_cal2 = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_done_reg", {16'd0, done_reg}, 32'd0);
        chk("reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-run: no write may appear (nothing queued).
        for (int i = 0; i < 4; i++) begin
            mem[i]       = 32'(i + 1);
            mem[256 + i] = 32'(i + 5);
        end
        stat_cal = 16'h0400;
        @(negedge clk);
        stat_cal = 16'h0401;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst_n    = 1'b0;
        stat_cal = 16'h0000;
        #1;
        chk("midrun_reset_done_reg", {16'd0, done_reg}, 32'd0);
        chk("midrun_reset_rd_addr", {19'd0, mem_rd_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(4, 32'd70, 1'b0);

        // Holding start high after done must not start a new run.
        repeat (10) @(negedge clk);
        chk("hold_no_retrigger", {16'd0, done_reg}, 32'h0401);
        stat_cal = 16'h0000;

        // Signed products and modulo accumulation.
        mem[0]   = 32'hFFFF8000;
        mem[1]   = 32'h00007FFF;
        mem[256] = 32'h00007FFF;
        mem[257] = 32'h00007FFF;
        run(2, 32'hFFFF8001, 1'b0);
        stat_cal = 16'h0000;
        mem[0] = 32'h12348000;
        run(2, 32'hFFFF8001, 1'b0);
        stat_cal = 16'h0000;

        // len = 0: immediate write of zero, no reads.
        run(0, 32'd0, 1'b0);
        stat_cal = 16'h0000;

        // Edge while busy is ignored: exactly one write.
        run(2, 32'hFFFF8001, 1'b1);
        repeat (20) @(negedge clk);
        chk("toggle_done_kept", {16'd0, done_reg}, 32'h0201);
        stat_cal = 16'h0000;

        // len = 255 boundary.
        for (int i = 0; i < 255; i++) begin
            mem[i]       = 32'd1;
            mem[256 + i] = 32'd1;
        end
        run(255, 32'd255, 1'b0);
        stat_cal = 16'h0000;

        // Address wrap on the A_BASE=8190 instance.
        mem2[8190] = 32'd1;
        mem2[8191] = 32'd2;
        mem2[0]    = 32'd3;
        mem2[1]    = 32'd4;
        for (int i = 0; i < 4; i++) mem2[256 + i] = 32'd1;
        exp_ra = '{13'd8190, 13'd256, 13'd8191, 13'd257, 13'd0, 13'd258, 13'd1, 13'd259};
        for (int i = 0; i < 8; i++) raq2.push_back(exp_ra[i]);
        e.addr = 13'd512;
        e.data = 32'd10;
        wq2.push_back(e);
        @(negedge clk);
        stat_cal2 = 16'h0400;
        @(negedge clk);
        stat_cal2 = 16'h0401;
        @(posedge clk);
        repeat (14) @(negedge clk);
        chk("wrap_done_reg", {16'd0, done_reg2}, 32'h0401);
        chk("wrap_reads_left", raq2.size(), 32'd0);
        stat_cal2 = 16'h0000;

        repeat (5) @(negedge clk);
        chk("writes_left", wq.size(), 32'd0);
        chk("writes_left2", wq2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
